// File: rtl/button_event_ctrl.sv
// Multi-channel push-button conditioner: sync, debounce, short/long/repeat
// events and post-release lockout, all timed by one shared 1 ms tick.
module button_event_ctrl #(
  parameter int N_CH        = 4,
  parameter int CLK_HZ      = 50_000_000,
  parameter int ACTIVE_LOW  = 1,
  parameter int DEBOUNCE_MS = 10,
  parameter int HOLD_MS     = 4000,
  parameter int REPEAT_MS   = 0,
  parameter int LOCKOUT_MS  = 1000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] btn_in,
  output logic [N_CH-1:0] short_pulse,
  output logic [N_CH-1:0] long_pulse,
  output logic [N_CH-1:0] repeat_pulse,
  output logic [N_CH-1:0] held,
  output logic [N_CH-1:0] busy
);

  localparam int DIV = CLK_HZ / 1000;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int DW  = (DEBOUNCE_MS > 0) ? $clog2(DEBOUNCE_MS + 1) : 1;
  localparam int HW  = $clog2(HOLD_MS + 1);
  localparam int RW  = (REPEAT_MS > 0) ? $clog2(REPEAT_MS + 1) : 1;
  localparam int LW  = (LOCKOUT_MS > 0) ? $clog2(LOCKOUT_MS + 1) : 1;

  localparam logic [PW-1:0] PRE_LAST  = PW'(DIV - 1);
  localparam logic [DW-1:0] DEB_LAST  =
    DW'((DEBOUNCE_MS > 0) ? DEBOUNCE_MS - 1 : 0);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_MS - 1);
  localparam logic [RW-1:0] REP_LAST  =
    RW'((REPEAT_MS > 0) ? REPEAT_MS - 1 : 0);
  localparam logic [LW-1:0] LOCK_MAX  = LW'(LOCKOUT_MS);
  localparam logic          REP_EN    = (REPEAT_MS > 0);
  localparam logic          POL       = (ACTIVE_LOW != 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRESS,
    S_HELD,
    S_LOCK
  } state_t;

  logic [PW-1:0] pre_cnt;
  logic          ms_tick;

  assign ms_tick = (pre_cnt == PRE_LAST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      pre_cnt <= '0;
    end else if (ms_tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic          s1;
    logic          s2;
    logic          p;
    logic          db;
    state_t        state;
    state_t        state_nxt;
    logic [HW-1:0] hold_cnt;
    logic [HW-1:0] hold_nxt;
    logic [RW-1:0] rep_cnt;
    logic [RW-1:0] rep_nxt;
    logic [LW-1:0] lock_cnt;
    logic [LW-1:0] lock_nxt;
    logic          short_q;
    logic          long_q;
    logic          rep_q;
    logic          short_nxt;
    logic          long_nxt;
    logic          repeat_nxt;

    // Sync flops reset to the idle pin level so reset never looks like a press.
    always_ff @(posedge clk) begin
      if (!rst) begin
        s1 <= POL;
        s2 <= POL;
      end else begin
        s1 <= btn_in[i];
        s2 <= s1;
      end
    end

    assign p = s2 ^ POL;

    if (DEBOUNCE_MS == 0) begin : g_bypass
      always_ff @(posedge clk) begin
        if (!rst) begin
          db <= 1'b0;
        end else begin
          db <= p;
        end
      end
    end else begin : g_deb
      logic [DW-1:0] deb_cnt;

      always_ff @(posedge clk) begin
        if (!rst) begin
          db      <= 1'b0;
          deb_cnt <= '0;
        end else if (p == db) begin
          deb_cnt <= '0;
        end else if (ms_tick) begin
          if (deb_cnt == DEB_LAST) begin
            db      <= p;
            deb_cnt <= '0;
          end else begin
            deb_cnt <= deb_cnt + 1'b1;
          end
        end
      end
    end

    always_ff @(posedge clk) begin
      if (!rst) begin
        state    <= S_IDLE;
        hold_cnt <= '0;
        rep_cnt  <= '0;
        lock_cnt <= '0;
        short_q  <= 1'b0;
        long_q   <= 1'b0;
        rep_q    <= 1'b0;
      end else begin
        state    <= state_nxt;
        hold_cnt <= hold_nxt;
        rep_cnt  <= rep_nxt;
        lock_cnt <= lock_nxt;
        short_q  <= short_nxt;
        long_q   <= long_nxt;
        rep_q    <= repeat_nxt;
      end
    end

    always_comb begin
      state_nxt  = state;
      hold_nxt   = hold_cnt;
      rep_nxt    = rep_cnt;
      lock_nxt   = lock_cnt;
      short_nxt  = 1'b0;
      long_nxt   = 1'b0;
      repeat_nxt = 1'b0;
      unique case (state)
        S_IDLE: begin
          if (db) begin
            state_nxt = S_PRESS;
            hold_nxt  = '0;
          end
        end
        S_PRESS: begin
          // Release is tested first so it beats a coincident hold expiry.
          if (!db) begin
            short_nxt = 1'b1;
            state_nxt = S_LOCK;
            lock_nxt  = '0;
          end else if (ms_tick) begin
            if (hold_cnt == HOLD_LAST) begin
              long_nxt  = 1'b1;
              state_nxt = S_HELD;
              rep_nxt   = '0;
            end else begin
              hold_nxt = hold_cnt + 1'b1;
            end
          end
        end
        S_HELD: begin
          if (!db) begin
            state_nxt = S_LOCK;
            lock_nxt  = '0;
          end else if (REP_EN && ms_tick) begin
            if (rep_cnt == REP_LAST) begin
              repeat_nxt = 1'b1;
              rep_nxt    = '0;
            end else begin
              rep_nxt = rep_cnt + 1'b1;
            end
          end
        end
        S_LOCK: begin
          if (ms_tick && (lock_cnt != LOCK_MAX)) begin
            lock_nxt = lock_cnt + 1'b1;
          end
          // A button still down at lockout end must be released first.
          if ((lock_cnt == LOCK_MAX) && !db) begin
            state_nxt = S_IDLE;
          end
        end
        default: begin
          state_nxt = S_IDLE;
        end
      endcase
    end

    assign short_pulse[i]  = short_q;
    assign long_pulse[i]   = long_q;
    assign repeat_pulse[i] = rep_q;
    assign held[i]         = (state == S_HELD);
    assign busy[i]         = (state != S_IDLE);
  end

endmodule
